kernel_mem: RTL and testbench



---
 rtl/kernel_mem_pkg.sv | 18 +
 rtl/kernel_load_counter.sv | 27 ++
 rtl/kernel_mem.sv | 73 +++++++
 tb/tb_kernel_mem.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/kernel_mem_pkg.sv
// Shared definitions for the kernel storage block and the convolution datapath
// that reads the kernel it holds.
package kernel_mem_pkg;

    // Default coefficient width and kernel edge length
    localparam int DEFAULT_BITS        = 9;
    localparam int DEFAULT_KERNEL_SIZE = 3;
    localparam int NUM_TAPS            = DEFAULT_KERNEL_SIZE * DEFAULT_KERNEL_SIZE;

    // Width of a counter that must be able to hold the value num_taps itself
    function automatic int count_w(input int num_taps);
        return $clog2(num_taps + 1);
    endfunction

    // One kernel coefficient as seen by the convolution datapath
    typedef logic [DEFAULT_BITS-1:0] coef_t;

endpackage

// File: rtl/kernel_load_counter.sv
// Saturating write counter: counts accepted coefficients up to NUM_TAPS and
// then holds, so a kernel that keeps being rewritten stays "full".
module kernel_load_counter #(
    parameter int NUM_TAPS = 9,
    parameter int COUNT_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               full
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(NUM_TAPS);

    assign full = (count == MAX_COUNT);

    // Count accepted writes; stop at NUM_TAPS so the value never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/kernel_mem.sv
// Serial-load kernel register file. Coefficients are shifted in at tap 0 and
// move toward tap NUM_TAPS-1; the flat out bus feeds the convolution datapath.
// Optional macro KERNEL_MEM_DONE_PULSE_EN adds a one-cycle done pulse on the
// cycle ready first rises after reset.
module kernel_mem
    import kernel_mem_pkg::*;
#(
    parameter  int BITS        = DEFAULT_BITS,
    parameter  int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
    localparam int TAPS        = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [BITS-1:0]      kernel_in,
    output logic                 ready,
`ifdef KERNEL_MEM_DONE_PULSE_EN
    output logic                 done,
`endif
    output logic [TAPS*BITS-1:0] out
);

    localparam int                 COUNT_W    = count_w(TAPS);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TAPS - 1);

    logic [COUNT_W-1:0] count;
    logic               full;
    logic               load_last;

    kernel_load_counter #(
        .NUM_TAPS (TAPS),
        .COUNT_W  (COUNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (write_en),
        .count (count),
        .full  (full)
    );

    // This write completes the first full kernel since reset
    assign load_last = write_en && !full && (count == LAST_COUNT);

    // Tap shift register: newest coefficient enters at the LSB end, oldest drops off the top
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (write_en) begin
            out <= {out[TAPS*BITS-BITS-1:0], kernel_in};
        end
    end

    // ready rises with the last coefficient of a load and is held until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
        end else if (load_last) begin
            ready <= 1'b1;
        end
    end

`ifdef KERNEL_MEM_DONE_PULSE_EN
    // done marks only the edge where ready goes 0->1; later writes cannot retrigger it
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= load_last;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_mem.sv
// Directed bench for kernel_mem: reset, write gating, ready timing, shift
// ordering, gapped loads, sliding writes after ready, and reset mid-load.
// Also covers the done pulse when KERNEL_MEM_DONE_PULSE_EN is defined.
`timescale 1ns/1ps
module tb_kernel_mem;

    localparam int BITS = 9;
    localparam int TAPS = 9;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 write_en;
    logic [BITS-1:0]      kernel_in;
    logic                 ready;
    logic [TAPS*BITS-1:0] out;
`ifdef KERNEL_MEM_DONE_PULSE_EN
    logic                 done;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Load of 1..9: tap8=1 down to tap0=9
    localparam logic [TAPS*BITS-1:0] ORDERED =
        81'b000000001_000000010_000000011_000000100_000000101_000000110_000000111_000001000_000001001;

    kernel_mem #(.BITS(BITS), .KERNEL_SIZE(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .write_en  (write_en),
        .kernel_in (kernel_in),
        .ready     (ready),
`ifdef KERNEL_MEM_DONE_PULSE_EN
        .done      (done),
`endif
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [BITS-1:0] v);
        kernel_in = v;
        write_en  = 1'b1;
        tick();
        write_en  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [BITS-1:0] tap(input int k);
        return out[k*BITS +: BITS];
    endfunction

    initial begin
        reset     = 1'b1;
        write_en  = 1'b0;
        kernel_in = 9'h0FF;

        // Reset check
        tick();
        check("reset_out", out, '0);
        check("reset_ready", ready, 1'b0);
`ifdef KERNEL_MEM_DONE_PULSE_EN
        check("reset_done", done, 1'b0);
`endif
        reset = 1'b0;

        // Write gating
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_out", out, '0);
            check("gate_ready", ready, 1'b0);
        end

        // Ready timing with a constant 0x0FF stream
        kernel_in = 9'h0FF;
        write_en  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("ready_early_%0d", i), ready, 1'b0);
        end
        tick();
        write_en = 1'b0;
        check("ready_9th", ready, 1'b1);
        for (int k = 0; k < TAPS; k++)
            check($sformatf("ff_tap%0d", k), tap(k), 9'h0FF);
`ifdef KERNEL_MEM_DONE_PULSE_EN
        check("done_first", done, 1'b1);
        tick();
        check("done_drop", done, 1'b0);
`endif

        // Ordering
        do_reset();
        check("order_cleared", out, '0);
        for (int v = 1; v <= 9; v++) wr(9'(v));
        check("order_out", out, ORDERED);
        check("order_ready", ready, 1'b1);

        // Gapped load, then a sliding write after ready
        do_reset();
        for (int v = 1; v <= 4; v++) wr(9'(v));
        tick();
        tick();
        check("gap_hold_ready", ready, 1'b0);
        check("gap_hold_tap0", tap(0), 9'd4);
        for (int v = 5; v <= 8; v++) wr(9'(v));
        check("gap_8_ready", ready, 1'b0);
        wr(9'd9);
        check("gap_9_ready", ready, 1'b1);
        check("gap_out", out, ORDERED);
        wr(9'd10);
        check("slide_tap0", tap(0), 9'd10);
        check("slide_tap8", tap(8), 9'd2);
        check("slide_ready", ready, 1'b1);

        // Reset mid-load, reset beats write_en
        do_reset();
        for (int v = 1; v <= 5; v++) wr(9'(20 + v));
        kernel_in = 9'h1AB;
        write_en  = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        write_en  = 1'b0;
        check("midrst_out", out, '0);
        check("midrst_ready", ready, 1'b0);
        for (int v = 1; v <= 8; v++) wr(9'(30 + v));
        check("reload_8_ready", ready, 1'b0);
`ifdef KERNEL_MEM_DONE_PULSE_EN
        check("reload_8_done", done, 1'b0);
`endif
        wr(9'd39);
        check("reload_9_ready", ready, 1'b1);
        check("reload_tap0", tap(0), 9'd39);
        check("reload_tap8", tap(8), 9'd31);
`ifdef KERNEL_MEM_DONE_PULSE_EN
        check("reload_9_done", done, 1'b1);
        tick();
        check("reload_done_drop", done, 1'b0);
        wr(9'd40);
        check("no_repulse", done, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus stalls
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
